// File: rtl/udp_top_hls_deadlock_param_monitor.sv
// Parametrised deadlock monitor for one HLS dataflow region of the UDP stack.
// It raises block after THRESH consecutive cycles where every process is idle or stalled and at least one is stalled on AXIS.
module udp_top_hls_deadlock_param_monitor #(
  parameter int NUM_PROC = 11,
  parameter int NUM_AXIS = 8,
  parameter int NUM_SUB  = 2,
  parameter logic [NUM_PROC*NUM_AXIS-1:0] AXIS_MAP = '0,
  parameter logic [NUM_PROC*NUM_SUB-1:0]  SUB_MAP  = '0,
  parameter int THRESH = 16,
  parameter int STICKY = 1,
  parameter int CNT_W  = 32,
  localparam int IDX_W = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [NUM_PROC-1:0] inst_idle_sigs,
  input  logic [NUM_PROC-1:0] inst_block_sigs,
  input  logic [NUM_SUB-1:0]  sub_block_sigs,
  input  logic                clear,
  output logic                block,
  output logic [IDX_W-1:0]    block_proc_idx,
  output logic [NUM_PROC-1:0] block_proc_vec,
  output logic [CNT_W-1:0]    stall_cycles,
  output logic [CNT_W-1:0]    deadlock_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SUSPECT  = 2'd1,
    DEADLOCK = 2'd2
  } state_t;

  state_t state_p1;
  state_t state_n;

  logic [NUM_PROC-1:0] gate_p0;
  logic [NUM_PROC-1:0] axb_p0;
  logic [NUM_PROC-1:0] stop_p0;
  logic                cond_p0;

  logic                block_n;
  logic [IDX_W-1:0]    idx_n;
  logic [NUM_PROC-1:0] vec_n;
  logic [CNT_W-1:0]    stall_n;
  logic [CNT_W-1:0]    count_n;
  logic [CNT_W-1:0]    stall_inc;
  logic                enter_dl;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_PROC-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = NUM_PROC - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // Stage p0: per-process stall classification. A process with no sub-monitor
  // mapping is ungated; otherwise its AXIS stall only counts while a mapped
  // nested monitor also reports a block.
  always_comb begin
    gate_p0 = '0;
    axb_p0  = '0;
    stop_p0 = '0;
    for (int i = 0; i < NUM_PROC; i++) begin
      gate_p0[i] = (SUB_MAP[i*NUM_SUB +: NUM_SUB] == '0) ||
                   (|(sub_block_sigs & SUB_MAP[i*NUM_SUB +: NUM_SUB]));
      axb_p0[i]  = (|(axis_block_sigs & AXIS_MAP[i*NUM_AXIS +: NUM_AXIS])) & gate_p0[i];
      stop_p0[i] = inst_idle_sigs[i] | inst_block_sigs[i] | axb_p0[i];
    end
  end

  assign cond_p0 = (|axb_p0) & (&stop_p0) & ~(&inst_idle_sigs);

  always_comb begin
    state_n   = state_p1;
    block_n   = block;
    idx_n     = block_proc_idx;
    vec_n     = block_proc_vec;
    stall_n   = stall_cycles;
    count_n   = deadlock_count;
    enter_dl  = 1'b0;
    stall_inc = sat_inc(stall_cycles);
    if (clear) begin
      state_n = RUN;
      block_n = 1'b0;
      idx_n   = '0;
      vec_n   = '0;
      stall_n = '0;
      count_n = '0;
    end else begin
      unique case (state_p1)
        RUN: begin
          if (cond_p0) begin
            stall_n = CNT_W'(1);
            if (THRESH <= 1) enter_dl = 1'b1;
            else             state_n  = SUSPECT;
          end else begin
            stall_n = '0;
          end
        end
        SUSPECT: begin
          if (!cond_p0) begin
            state_n = RUN;
            stall_n = '0;
          end else begin
            stall_n = stall_inc;
            if (stall_inc >= CNT_W'(THRESH)) enter_dl = 1'b1;
          end
        end
        DEADLOCK: begin
          // Captures are frozen here; only the episode length keeps moving.
          if (cond_p0) begin
            stall_n = stall_inc;
          end else if (STICKY == 0) begin
            state_n = RUN;
            block_n = 1'b0;
            stall_n = '0;
          end
        end
        default: state_n = RUN;
      endcase
      if (enter_dl) begin
        state_n = DEADLOCK;
        block_n = 1'b1;
        vec_n   = axb_p0;
        idx_n   = lowest_idx(axb_p0);
        count_n = sat_inc(deadlock_count);
      end
    end
  end

  // Stage p1: registered state and outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_p1       <= RUN;
      block          <= 1'b0;
      block_proc_idx <= '0;
      block_proc_vec <= '0;
      stall_cycles   <= '0;
      deadlock_count <= '0;
    end else begin
      state_p1       <= state_n;
      block          <= block_n;
      block_proc_idx <= idx_n;
      block_proc_vec <= vec_n;
      stall_cycles   <= stall_n;
      deadlock_count <= count_n;
    end
  end

endmodule
